// File: rtl/wave_gen_pkg.sv
// Shared definitions for the wave_gen block: waveform mode encodings.
package wave_gen_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_SQUARE = 2'b01,
      MODE_SAW    = 2'b10,
      MODE_TRI    = 2'b11
   } wave_mode_e;

endpackage

// File: rtl/wave_gen_if.sv
// Control and sample bus of wave_gen. The controller side drives configuration
// and run controls; the generator side returns the sample and status.
interface wave_gen_if #(
   parameter int RES_BITS = 8,
   parameter int ACC_BITS = 16
);

   logic                enable;
   logic [ACC_BITS-1:0] tune;
   logic [RES_BITS-1:0] duty;
   logic [1:0]          mode;
   logic                cfg_load;
   logic                phase_clr;
   logic [RES_BITS-1:0] wave_out;
   logic                wrap;
   logic                cfg_pending;

   modport master (
      output enable, tune, duty, mode, cfg_load, phase_clr,
      input  wave_out, wrap, cfg_pending
   );

   modport slave (
      input  enable, tune, duty, mode, cfg_load, phase_clr,
      output wave_out, wrap, cfg_pending
   );

endinterface

// File: rtl/wave_gen_shaper.sv
// Combinational map from the phase top bits to a sample value for the active
// mode. Holds no state; registering happens in wave_gen.
module wave_shaper
   import wave_gen_pkg::*;
#(
   parameter int RES_BITS = 8
) (
   input  logic [RES_BITS-1:0] top,
   input  wave_mode_e          mode,
   input  logic [RES_BITS-1:0] duty,
   output logic [RES_BITS-1:0] sample
);

   // Rising half of the triangle: top doubled; the falling half is its inverse.
   logic [RES_BITS-1:0] ramp;
   assign ramp = {top[RES_BITS-2:0], 1'b0};

   // Select the sample for the active mode; duty of 0 keeps square at 0.
   always_comb begin
      sample = '0;
      case (mode)
         MODE_OFF:    sample = '0;
         MODE_SQUARE: sample = (top < duty) ? '1 : '0;
         MODE_SAW:    sample = top;
         MODE_TRI:    sample = top[RES_BITS-1] ? ~ramp : ramp;
      endcase
   end

endmodule

// File: rtl/wave_gen.sv
// Phase-accumulator waveform generator with double-buffered configuration.
// A new configuration waits in the pending set and is swapped into the active
// set only at a phase wrap, a phase restart, or while idle, so a running
// output never changes shape or frequency mid-period.
module wave_gen
   import wave_gen_pkg::*;
#(
   parameter int RES_BITS = 8,
   parameter int ACC_BITS = 16
) (
   input logic       clk,
   input logic       reset_n,
   wave_gen_if.slave bus
);

   localparam logic [RES_BITS-1:0] DUTY_RST = {1'b1, {(RES_BITS-1){1'b0}}};

   logic [ACC_BITS-1:0] phase;
   logic [ACC_BITS:0]   phase_sum;
   logic                carry;
   logic                apply;
   logic [RES_BITS-1:0] top;
   logic [RES_BITS-1:0] sample;

   logic [ACC_BITS-1:0] tune_a;
   logic [RES_BITS-1:0] duty_a;
   wave_mode_e          mode_a;
   logic [ACC_BITS-1:0] tune_p;
   logic [RES_BITS-1:0] duty_p;
   wave_mode_e          mode_p;
   logic                cfg_pending_q;

   logic [RES_BITS-1:0] wave_out_q;
   logic                wrap_q;

   assign phase_sum = {1'b0, phase} + {1'b0, tune_a};
   assign carry     = bus.enable & ~bus.phase_clr & phase_sum[ACC_BITS];

   // With tune_a=0 or enable low the output is frozen, so swapping is safe.
   assign apply     = carry | bus.phase_clr | ~bus.enable | (tune_a == '0);
   assign top       = phase[ACC_BITS-1 -: RES_BITS];

   wave_shaper #(
      .RES_BITS (RES_BITS)
   ) u_shaper (
      .top    (top),
      .mode   (mode_a),
      .duty   (duty_a),
      .sample (sample)
   );

   // Phase accumulator and the wrap pulse that marks each carry-out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase  <= '0;
         wrap_q <= 1'b0;
      end else begin
         if (bus.phase_clr) begin
            phase <= '0;
         end else if (bus.enable) begin
            phase <= phase_sum[ACC_BITS-1:0];
         end
         wrap_q <= carry;
      end
   end

   // Pending/active configuration; a load on an apply edge queues behind the
   // values being applied.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tune_a        <= '0;
         duty_a        <= DUTY_RST;
         mode_a        <= MODE_OFF;
         tune_p        <= '0;
         duty_p        <= DUTY_RST;
         mode_p        <= MODE_OFF;
         cfg_pending_q <= 1'b0;
      end else begin
         if (apply) begin
            tune_a <= tune_p;
            duty_a <= duty_p;
            mode_a <= mode_p;
         end
         if (bus.cfg_load) begin
            tune_p        <= bus.tune;
            duty_p        <= bus.duty;
            mode_p        <= wave_mode_e'(bus.mode);
            cfg_pending_q <= 1'b1;
         end else if (apply) begin
            cfg_pending_q <= 1'b0;
         end
      end
   end

   // Output sample register: one cycle behind the phase it was shaped from.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wave_out_q <= '0;
      end else begin
         wave_out_q <= sample;
      end
   end

   assign bus.wave_out    = wave_out_q;
   assign bus.wrap        = wrap_q;
   assign bus.cfg_pending = cfg_pending_q;

endmodule

// File: tb/tb_wave_gen.sv
// Bench for wave_gen (RES_BITS=8, ACC_BITS=16): directed waveform scenarios
// with closed-form expectations, then randomized traffic against a
// cycle-level arithmetic reference model.
module tb_wave_gen;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   wave_gen_if #(.RES_BITS(8), .ACC_BITS(16)) bus ();

   wave_gen #(
      .RES_BITS (8),
      .ACC_BITS (16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   int m_phase, m_tune_a, m_duty_a, m_mode_a;
   int m_tune_p, m_duty_p, m_mode_p;
   int m_pend, m_wave, m_wrap;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int shape(input int top, input int mode, input int duty);
      case (mode)
         1:       return (top < duty) ? 255 : 0;
         2:       return top;
         3:       return (top < 128) ? 2 * top : 255 - 2 * (top - 128);
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_tune_a = 0;   m_duty_a = 128; m_mode_a = 0;
      m_tune_p = 0;   m_duty_p = 128; m_mode_p = 0;
      m_pend   = 0;   m_wave   = 0;   m_wrap   = 0;
   endtask

   task automatic model_step();
      int sum;
      int carry;
      int app;
      sum    = m_phase + m_tune_a;
      carry  = (bus.enable === 1'b1 && bus.phase_clr !== 1'b1 && sum >= 65536) ? 1 : 0;
      app    = (carry == 1 || bus.phase_clr === 1'b1 || bus.enable !== 1'b1 || m_tune_a == 0) ? 1 : 0;
      m_wave = shape(m_phase / 256, m_mode_a, m_duty_a);
      m_wrap = carry;
      if (bus.phase_clr === 1'b1) m_phase = 0;
      else if (bus.enable === 1'b1) m_phase = sum % 65536;
      if (app == 1) begin
         m_tune_a = m_tune_p;
         m_duty_a = m_duty_p;
         m_mode_a = m_mode_p;
      end
      if (bus.cfg_load === 1'b1) begin
         m_tune_p = int'(bus.tune);
         m_duty_p = int'(bus.duty);
         m_mode_p = int'(bus.mode);
         m_pend   = 1;
      end else if (app == 1) begin
         m_pend = 0;
      end
   endtask

   // One clock: advance the model, let the edge pass, compare every output.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("m_wave", bus.wave_out, m_wave[7:0]);
      chk("m_wrap", bus.wrap, m_wrap[0]);
      chk("m_pend", bus.cfg_pending, m_pend[0]);
   endtask

   task automatic load(input logic [15:0] t, input logic [7:0] d, input logic [1:0] m);
      bus.cfg_load = 1'b1;
      bus.tune     = t;
      bus.duty     = d;
      bus.mode     = m;
   endtask

   // Idle load, then a phase restart so the run starts from phase 0.
   task automatic setup(input logic [15:0] t, input logic [7:0] d, input logic [1:0] m);
      bus.enable = 1'b0;
      load(t, d, m);
      tick();
      bus.cfg_load  = 1'b0;
      bus.phase_clr = 1'b1;
      tick();
      bus.phase_clr = 1'b0;
      bus.enable    = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_w;
      int j;
      reset_n       = 1'b0;
      bus.enable    = 1'b0;
      bus.cfg_load  = 1'b0;
      bus.phase_clr = 1'b0;
      bus.tune      = '0;
      bus.duty      = '0;
      bus.mode      = '0;
      model_reset();
      #2;
      chk("rst_wave", bus.wave_out, 0);
      chk("rst_wrap", bus.wrap, 0);
      chk("rst_pend", bus.cfg_pending, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // square: 8 high, 8 low, wrap every 16
      bus.enable = 1'b0;
      load(16'h1000, 8'h80, 2'b01);
      tick();
      chk("sq_pend_set", bus.cfg_pending, 1);
      bus.cfg_load  = 1'b0;
      bus.phase_clr = 1'b1;
      tick();
      chk("sq_pend_clr", bus.cfg_pending, 0);
      bus.phase_clr = 1'b0;
      bus.enable    = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick();
         chk("sq_wave", bus.wave_out, (((k - 1) % 16) < 8) ? 32'hFF : 32'h0);
         chk("sq_wrap", bus.wrap, (k % 16 == 0) ? 1 : 0);
      end

      // sawtooth: ramps 0..255, wrap once per 256
      setup(16'h0100, 8'h80, 2'b10);
      for (int k = 1; k <= 257; k++) begin
         tick();
         chk("saw_wave", bus.wave_out, (k - 1) % 256);
         chk("saw_wrap", bus.wrap, (k % 256 == 0) ? 1 : 0);
      end

      // triangle: 0,4..FC then FF,FB..03, period 128
      setup(16'h0200, 8'h80, 2'b11);
      for (int k = 1; k <= 130; k++) begin
         tick();
         j = (k - 1) % 128;
         exp_w = (j < 64) ? 4 * j : 255 - 4 * (j - 64);
         chk("tri_wave", bus.wave_out, exp_w);
         chk("tri_wrap", bus.wrap, (k % 128 == 0) ? 1 : 0);
      end

      // retune mid-period: current period finishes at 16, then 32-cycle periods
      setup(16'h1000, 8'h80, 2'b01);
      for (int k = 1; k <= 80; k++) begin
         if (k == 5) load(16'h0800, 8'h80, 2'b01);
         else bus.cfg_load = 1'b0;
         tick();
         if (k <= 16) exp_w = (((k - 1) % 16) < 8) ? 255 : 0;
         else exp_w = (((k - 17) % 32) < 16) ? 255 : 0;
         chk("rt_wave", bus.wave_out, exp_w);
         chk("rt_wrap", bus.wrap, (k == 16 || k == 48 || k == 80) ? 1 : 0);
         if (k == 5 || k == 15) chk("rt_pend_hi", bus.cfg_pending, 1);
         if (k == 16) chk("rt_pend_lo", bus.cfg_pending, 0);
      end

      // collision: load on the carry edge keeps pending set until next wrap
      for (int k = 81; k <= 140; k++) begin
         if (k == 81) load(16'h1000, 8'h80, 2'b01);
         else if (k == 112) load(16'h0400, 8'h80, 2'b10);
         else bus.cfg_load = 1'b0;
         tick();
         if (k <= 112) exp_w = (((k - 81) % 32) < 16) ? 255 : 0;
         else if (k <= 128) exp_w = ((k - 113) < 8) ? 255 : 0;
         else exp_w = (k - 129) * 4;
         chk("col_wave", bus.wave_out, exp_w);
         chk("col_wrap", bus.wrap, (k == 112 || k == 128) ? 1 : 0);
         if (k >= 81 && k <= 127) chk("col_pend_hi", bus.cfg_pending, 1);
         if (k == 128) chk("col_pend_lo", bus.cfg_pending, 0);
      end

      // reset mid-period with a pending configuration
      load(16'h0123, 8'h40, 2'b01);
      tick();
      bus.cfg_load = 1'b0;
      tick();
      chk("pre_rst_pend", bus.cfg_pending, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_wave", bus.wave_out, 0);
      chk("mid_rst_wrap", bus.wrap, 0);
      chk("mid_rst_pend", bus.cfg_pending, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) tick();

      // randomized traffic against the reference model
      for (int n = 0; n < 2000; n++) begin
         bus.enable    = ($urandom_range(0, 9) != 0);
         bus.cfg_load  = ($urandom_range(0, 19) == 0);
         bus.phase_clr = ($urandom_range(0, 99) == 0);
         case ($urandom_range(0, 3))
            0:       bus.tune = 16'h0000;
            1:       bus.tune = 16'($urandom);
            2:       bus.tune = 16'($urandom_range(16'h0100, 16'h2000));
            default: bus.tune = 16'($urandom_range(16'hFF00, 16'hFFFF));
         endcase
         bus.duty = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         bus.mode = 2'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
